// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, FSM states
// and the opcode classification helper.
package mdu_hilo_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

    // Only these four opcodes occupy the iterative datapath.
    function automatic logic isIterOp(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_hilo_divstep.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted partial remainder, plus the resulting quotient bit.
module mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             qBit_o
);

    // rem_i < 2*divisor, so a successful subtraction always fits in WIDTH bits.
    assign qBit_o = (rem_i >= {1'b0, divisor_i});
    assign diff_o = rem_i[WIDTH-1:0] - divisor_i;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers; one
// result bit per cycle over WIDTH iterations followed by a sign-fix cycle.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               isDiv_q, isDiv_d;
    logic               negLo_q, negLo_d;
    logic               negHi_q, negHi_d;
    logic               byZero_q, byZero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dzPulse_q, dzPulse_d;

    logic               signedOp;
    logic               divOp;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH-1:0]   divDiff;
    logic               divQBit;
    logic [WIDTH-1:0]   divRem;
    logic [2*WIDTH-1:0] product;

    assign signedOp = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    assign divOp    = (op_i == MDU_DIV)  || (op_i == MDU_DIVU);
    assign absA     = (signedOp && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
    assign absB     = (signedOp && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;

    // Multiply keeps the multiplier in the low half and shifts it out LSB first.
    assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide keeps {remainder, dividend/quotient}; the next dividend bit enters from the top of the low half.
    assign divShift = acc_q[2*WIDTH-1:WIDTH-1];
    assign divRem   = divQBit ? divDiff : divShift[WIDTH-1:0];
    assign product  = negLo_q ? -acc_q : acc_q;

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_i     (divShift),
        .divisor_i (opnd_q),
        .diff_o    (divDiff),
        .qBit_o    (divQBit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        isDiv_d   = isDiv_q;
        negLo_d   = negLo_q;
        negHi_d   = negHi_q;
        byZero_d  = byZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dzPulse_d = 1'b0;

        unique case (state_q)
            MDU_IDLE: begin
                if (start_i && isIterOp(op_i)) begin
                    state_d  = MDU_RUN;
                    cnt_d    = '0;
                    isDiv_d  = divOp;
                    acc_d    = divOp ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
                    opnd_d   = divOp ? absB : absA;
                    negLo_d  = signedOp && (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
                    negHi_d  = signedOp && src_a_i[WIDTH-1];
                    byZero_d = divOp && (src_b_i == '0);
                end else if (start_i && (op_i == MDU_MTHI)) begin
                    hi_d = src_a_i;
                end else if (start_i && (op_i == MDU_MTLO)) begin
                    lo_d = src_a_i;
                end
            end
            MDU_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (isDiv_q) begin
                    acc_d = {divRem, acc_q[WIDTH-2:0], divQBit};
                end else begin
                    acc_d = {mulSum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = MDU_FIX;
                end
            end
            MDU_FIX: begin
                state_d   = MDU_IDLE;
                done_d    = 1'b1;
                dzPulse_d = byZero_q;
                if (isDiv_q) begin
                    lo_d = negLo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = negHi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    // A zero divisor leaves |a| as remainder, which the sign fix turns back into src_a.
                    if (byZero_q) begin
                        lo_d = '1;
                    end
                end else begin
                    {hi_d, lo_d} = product;
                end
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase

        if (flush_i && (state_q != MDU_IDLE)) begin
            state_d   = MDU_IDLE;
            hi_d      = hi_q;
            lo_d      = lo_q;
            done_d    = 1'b0;
            dzPulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            isDiv_q   <= 1'b0;
            negLo_q   <= 1'b0;
            negHi_q   <= 1'b0;
            byZero_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dzPulse_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            isDiv_q   <= isDiv_d;
            negLo_q   <= negLo_d;
            negHi_q   <= negHi_d;
            byZero_q  <= byZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dzPulse_q <= dzPulse_d;
        end
    end

    assign busy_o     = (state_q != MDU_IDLE);
    assign done_o     = done_q;
    assign div_zero_o = dzPulse_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule
